// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for a 5-stage RISC-V pipeline: E-operand forwarding selects,
// load-use / taken-branch / multi-cycle stall and flush control. Optional macro: HAZ_WB_BYPASS_EN.
module hazard_fwd_ctrl #(
   parameter int REG_AW = 5,
   parameter int MC_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              regwrite_d,
   input  logic              load_d,
   input  logic              mc_d,
   input  logic              pcsrc_e,
   output logic [1:0]        forward_ae,
   output logic [1:0]        forward_be,
   output logic              fwd_d1,
   output logic              fwd_d2,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m
);

   localparam int CW = $clog2(MC_LAT) + 1;
   localparam logic [CW-1:0] MC_MAX = CW'(MC_LAT - 1);

   typedef struct packed {
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              load;
      logic              mc;
   } e_state_t;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              regwrite;
   } wr_state_t;

   e_state_t  e_q;
   wr_state_t m_q;
   wr_state_t w_q;
   logic [CW-1:0] mc_cnt;

   logic mc_busy;
   logic lw_stall;

   // The counter only runs while a multi-cycle op is parked in E, so it stops at MC_MAX.
   assign mc_busy  = e_q.mc && (mc_cnt < MC_MAX);
   assign lw_stall = e_q.load && (e_q.rd != '0) &&
                     ((e_q.rd == rs1_d) || (e_q.rd == rs2_d)) && !mc_busy;

   // NOTE: every output is defaulted first so no path through the block can infer a latch.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      if (mc_busy) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         flush_m = 1'b1;
      end else if (pcsrc_e) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (lw_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   always_comb begin
      forward_ae = 2'b00;
      if (m_q.regwrite && (m_q.rd != '0) && (m_q.rd == e_q.rs1))
         forward_ae = 2'b10;
      else if (w_q.regwrite && (w_q.rd != '0) && (w_q.rd == e_q.rs1))
         forward_ae = 2'b01;
   end

   always_comb begin
      forward_be = 2'b00;
      if (m_q.regwrite && (m_q.rd != '0) && (m_q.rd == e_q.rs2))
         forward_be = 2'b10;
      else if (w_q.regwrite && (w_q.rd != '0) && (w_q.rd == e_q.rs2))
         forward_be = 2'b01;
   end

`ifdef HAZ_WB_BYPASS_EN
   assign fwd_d1 = w_q.regwrite && (w_q.rd != '0) && (w_q.rd == rs1_d);
   assign fwd_d2 = w_q.regwrite && (w_q.rd != '0) && (w_q.rd == rs2_d);
`else
   assign fwd_d1 = 1'b0;
   assign fwd_d2 = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so all stages shift off the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q    <= '0;
         m_q    <= '0;
         w_q    <= '0;
         mc_cnt <= '0;
      end else begin
         if (flush_e)
            e_q <= '0;
         else if (!stall_e)
            e_q <= '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                     regwrite: regwrite_d, load: load_d, mc: mc_d};

         if (flush_e || !stall_e)
            mc_cnt <= '0;
         else if (mc_busy)
            mc_cnt <= mc_cnt + CW'(1);

         if (flush_m)
            m_q <= '0;
         else
            m_q <= '{rd: e_q.rd, regwrite: e_q.regwrite};

         w_q <= m_q;
      end
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Keeps its own E/M/W copies of register-address and write-control state, tracked from decode-stage inputs.
- Drives the 2-bit select codes of the E-stage operand mux3 instances, plus the stall and flush controls for the pipeline registers.
- Handles load-use stalls, taken-branch flushes and multi-cycle E-stage operations (MUL/DIV) of fixed latency.

Parameters:
- REG_AW, 5, register-address width (x0..x31).
- MC_LAT, 4, cycles a multi-cycle op occupies E; must be >=1; 1 means no extra stall.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rs1_d  input  REG_AW  source register 1 of the instruction in D.
- rs2_d  input  REG_AW  source register 2 of the instruction in D.
- rd_d  input  REG_AW  destination register of the instruction in D.
- regwrite_d  input  1  instruction in D writes rd.
- load_d  input  1  instruction in D is a load (result comes from memory).
- mc_d  input  1  instruction in D is a multi-cycle E op.
- pcsrc_e  input  1  branch/jump in E is taken.
- forward_ae  output  2  mux3 select for SrcA in E: 00 regfile, 01 W result, 10 M ALU result.
- forward_be  output  2  same encoding, SrcB.
- fwd_d1  output  1  mux2 select, D read port 1: 1 = W result (optional feature).
- fwd_d2  output  1  same, read port 2.
- stall_f  output  1  hold PC.
- stall_d  output  1  hold F/D register.
- stall_e  output  1  hold D/E register.
- flush_d  output  1  clear F/D register.
- flush_e  output  1  clear D/E register (bubble).
- flush_m  output  1  clear E/M register (bubble).

Behaviour:
- Internal state: E{rs1,rs2,rd,regwrite,load,mc}, M{rd,regwrite}, W{rd,regwrite}, plus counter mc_cnt (width ceil(log2(MC_LAT))+1).
- Reset, asynchronous: all internal fields 0 and mc_cnt=0, so every output reads 0 during and immediately after reset.
- Reset mid-stall drops the stall immediately.

Stall and flush conditions (combinational from state + inputs):
- mc_busy = E.mc && (mc_cnt < MC_LAT-1).
- lw_stall = E.load && E.rd!=0 && (E.rd==rs1_d || E.rd==rs2_d) && !mc_busy.
- Priority, highest first: mc_busy, then pcsrc_e, then lw_stall.
- mc_busy: stall_f=stall_d=stall_e=1, flush_m=1; pcsrc_e and lw_stall are ignored.
- Otherwise pcsrc_e: flush_d=1, flush_e=1; no stall.
- Otherwise lw_stall: stall_f=stall_d=1, flush_e=1.
- All unlisted outputs are 0.

Forwarding, evaluated for rs1 (→ forward_ae) and rs2 (→ forward_be):
- 10 if M.regwrite && M.rd!=0 && M.rd==E.rs.
- Else 01 if W.regwrite && W.rd!=0 && W.rd==E.rs.
- Else 00.
- M wins over W when both match. Code 11 is never produced.
- Forwarding is computed even while stalled.

State update at each rising edge:
- E: flush_e → all fields 0; else stall_e → hold; else load from the *_d inputs.
- mc_cnt: 0 whenever E loads or is flushed; +1 while mc_busy; saturates at MC_LAT-1.
- M: flush_m → regwrite=0, rd=0; else load from E.
- W: always load from M.
- A load followed directly by a dependent instruction gives one bubble, then W-forwarding (01).
- MC_LAT=1: mc_busy is never asserted.

Optional Feature:
- Macro: HAZ_WB_BYPASS_EN.
- Defined: fwd_d1 = W.regwrite && W.rd!=0 && W.rd==rs1_d; fwd_d2 likewise for rs2_d. Covers a same-cycle regfile write/read, for register files without write-first behaviour.
- Undefined: fwd_d1 and fwd_d2 are tied to 0. Ports stay present.

Test Plan:
- Back-to-back add x5 then sub x6,x5,x7 → cycle after sub enters E: forward_ae=10, forward_be=00; one cycle later, an instruction reading x5 in E gets 01.
- lw x5 then add x6,x5,x5 → one cycle stall_f=stall_d=flush_e=1, then add in E with forward_ae=forward_be=01, no further stall.
- Writes and reads of x0 (rd=0, regwrite=1) → forward_ae/be stay 00 and no load-use stall.
- mul (mc_d=1) with MC_LAT=4 → stall_f/d/e and flush_m high for exactly 3 cycles after mul enters E, then released; pcsrc_e=1 pulsed mid-stall is ignored.
- pcsrc_e=1 with a load-use match pending → flush_d=flush_e=1, stall_f=stall_d=0.
- reset asserted during an mc stall → all outputs 0 asynchronously. With HAZ_WB_BYPASS_EN, rd_w=rs1_d=9 → fwd_d1=1; without the macro → 0.
